// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Optional readback/verify support is enabled by defining CFG_CHAIN_READBACK_EN.
package cfg_loader_pkg;

    // CRC-16/CCITT polynomial and seed used for load/readback signatures
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Loader states; VERIFY only exists when readback is compiled in
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        SHIFT     = 3'd2,
`ifdef CFG_CHAIN_READBACK_EN
        VERIFY    = 3'd3,
`endif
        DONE      = 3'd4
    } state_t;

    // Number of bitstream words needed to fill a chain of chain_len bits
    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // One MSB-first serial CRC step: feedback is crc[15] xor the incoming bit
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16 accumulator; clear reseeds, bit_en folds in one bit.
module cfg_crc16_serial
    import cfg_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    // Signature register: reset to 0, reseed on clear, advance one bit per enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (bit_en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises a W-bit word stream onto a CGRA ConfigCell chain, one bit per
// chain_shift_en cycle, bit 0 of each word first.
// Define CFG_CHAIN_READBACK_EN to add a VERIFY pass that rotates the chain
// once through chain_out and compares CRC-16 signatures of load and readback.
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              chain_in,
    input  logic              chain_out,
    output logic              chain_shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_loaded,
    output logic              error
);

    // A word never shifts more bits than the chain holds, so cap it once here
    localparam int              WORD_CAP = (WORD_W < CHAIN_LEN) ? WORD_W : CHAIN_LEN;
    localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_C  = CNT_W'(WORD_CAP);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

`ifdef CFG_CHAIN_READBACK_EN
    localparam state_t AFTER_LOAD = VERIFY;
`else
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t            state, state_d;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  n_cnt;
    logic [CNT_W-1:0]  bits_q;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  n_load;
    logic              begin_load;
    logic              take_word;

    assign bits_loaded = bits_q;

    // Bits still owed to the chain decide how much of the next word is used;
    // the upper bits of a short final word are simply never shifted.
    assign rem    = LEN_C - bits_q;
    assign n_load = (rem > WORD_C) ? WORD_C : rem;

`ifdef CFG_CHAIN_READBACK_EN
    logic [CNT_W-1:0] vcnt;
    logic             verify_end;
    logic             error_q;
    logic [15:0]      crc_load;
    logic [15:0]      crc_rb;
`endif

    // Next-state and Moore outputs; abort overrides every transition at the end
    always_comb begin
        state_d        = state;
        cfg_ready      = 1'b0;
        chain_shift_en = 1'b0;
        chain_in       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        begin_load     = 1'b0;
        take_word      = 1'b0;
`ifdef CFG_CHAIN_READBACK_EN
        verify_end     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_d    = WAIT_WORD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    begin_load = 1'b1;
                    state_d    = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                busy      = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    take_word = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy           = 1'b1;
                chain_shift_en = 1'b1;
                chain_in       = shreg[0];
                if (n_cnt == ONE_C) begin
                    state_d = (bits_q + ONE_C == LEN_C) ? AFTER_LOAD : WAIT_WORD;
                end
            end
`ifdef CFG_CHAIN_READBACK_EN
            VERIFY: begin
                // Feed the chain its own output so it ends up holding the load again
                busy           = 1'b1;
                chain_shift_en = 1'b1;
                chain_in       = chain_out;
                if (vcnt == LEN_C - ONE_C) begin
                    verify_end = 1'b1;
                    state_d    = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (abort && state != IDLE) begin
            state_d    = IDLE;
            begin_load = 1'b0;
            take_word  = 1'b0;
`ifdef CFG_CHAIN_READBACK_EN
            verify_end = 1'b0;
`endif
        end
    end

    // State, word shift register, per-word bit budget and load progress counter
    always_ff @(posedge Config_Clock) begin
        if (!Config_Reset) begin
            state  <= IDLE;
            shreg  <= '0;
            n_cnt  <= '0;
            bits_q <= '0;
        end else begin
            state <= state_d;

            if (begin_load) begin
                bits_q <= '0;
            end else if (state == SHIFT) begin
                bits_q <= bits_q + ONE_C;
            end

            if (take_word) begin
                shreg <= cfg_data;
                n_cnt <= n_load;
            end else if (state == SHIFT) begin
                shreg <= shreg >> 1;
                n_cnt <= n_cnt - ONE_C;
            end
        end
    end

`ifdef CFG_CHAIN_READBACK_EN
    // Signature of every bit pushed into the chain during the load
    cfg_crc16_serial u_crc_load (
        .clk    (Config_Clock),
        .rst_n  (Config_Reset),
        .clear  (begin_load),
        .bit_en (state == SHIFT),
        .bit_in (shreg[0]),
        .crc    (crc_load)
    );

    // Signature of what comes back out while the chain rotates once
    cfg_crc16_serial u_crc_rb (
        .clk    (Config_Clock),
        .rst_n  (Config_Reset),
        .clear  (begin_load),
        .bit_en (state == VERIFY),
        .bit_in (chain_out),
        .crc    (crc_rb)
    );

    // Rotation counter; compare signatures including the bit seen on the final cycle
    always_ff @(posedge Config_Clock) begin
        if (!Config_Reset) begin
            vcnt    <= '0;
            error_q <= 1'b0;
        end else begin
            vcnt <= (state == VERIFY) ? vcnt + ONE_C : '0;
            if (begin_load) begin
                error_q <= 1'b0;
            end else if (verify_end) begin
                error_q <= (crc_load != crc16_step(crc_rb, chain_out));
            end
        end
    end

    assign error = error_q;
`else
    // Readback path absent: chain_out is not observed and no mismatch can be flagged
    logic unused_chain_out;
    assign unused_chain_out = chain_out;
    assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: default 40-bit chain plus a 64-bit
// exact-multiple instance, each driving a behavioural ConfigCell chain.
module tb_cfg_chain_loader;

    localparam logic [31:0] W0 = 32'hA5A5_0001;
    localparam logic [31:0] W1 = 32'h0000_00C3;
    localparam logic [31:0] X0 = 32'h1234_5678;
    localparam logic [31:0] X1 = 32'h9ABC_DEF0;
`ifdef CFG_CHAIN_READBACK_EN
    localparam int VCYC   = 40;
    localparam int VCYC64 = 64;
`else
    localparam int VCYC   = 0;
    localparam int VCYC64 = 0;
`endif

    int total = 0;
    int bad   = 0;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, cfg_valid;
    logic [31:0] cfg_data;
    logic        cfg_ready, chain_in, chain_out, chain_shift_en, busy, done, error;
    logic [15:0] bits_loaded;

    logic        q_start, q_valid;
    logic [31:0] q_data;
    logic        q_ready, q_ci, q_co, q_se, q_busy, q_done, q_error;
    logic [15:0] q_bits;

    logic [39:0] chain      = '0;
    logic [39:0] stuck_mask = '0;
    logic [63:0] chain64    = '0;

    always #5 clk = ~clk;

    cfg_chain_loader dut (
        .Config_Clock   (clk),
        .Config_Reset   (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .chain_in       (chain_in),
        .chain_out      (chain_out),
        .chain_shift_en (chain_shift_en),
        .busy           (busy),
        .done           (done),
        .bits_loaded    (bits_loaded),
        .error          (error)
    );

    cfg_chain_loader #(.CHAIN_LEN(64)) dut64 (
        .Config_Clock   (clk),
        .Config_Reset   (rst_n),
        .start          (q_start),
        .abort          (1'b0),
        .cfg_data       (q_data),
        .cfg_valid      (q_valid),
        .cfg_ready      (q_ready),
        .chain_in       (q_ci),
        .chain_out      (q_co),
        .chain_shift_en (q_se),
        .busy           (q_busy),
        .done           (q_done),
        .bits_loaded    (q_bits),
        .error          (q_error)
    );

    // Behavioural chains: cell 0 takes chain_in, the last cell drives chain_out
    always @(posedge clk) begin
        if (chain_shift_en) chain <= {chain[38:0], chain_in} & ~stuck_mask;
        if (q_se) chain64 <= {chain64[62:0], q_ci};
    end
    assign chain_out = chain[39];
    assign q_co      = chain64[63];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full two-word load on the 40-bit instance, with an optional valid gap
    task automatic do_load(input string tag, input int gap, input logic exp_err,
                           input logic check_chain);
        int   widx = 0, gapcnt = 0, run = 0, rdy_cnt = 0, shifts = 0;
        int   last_sh = -1, done_cyc = -1, nmis = 0;
        logic gap_bad = 1'b0, busy_bad = 1'b0;
        logic q[$];
        int   bursts[$];
        logic [39:0] stream, exp_chain;
        stream = {W1[7:0], W0};
        for (int k = 0; k < 40; k++) exp_chain[39-k] = stream[k];

        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " start clears done"}, done, 0);
        chk({tag, " start clears bits"}, bits_loaded, 0);
        chk({tag, " start clears error"}, error, 0);

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (chain_shift_en) begin
                q.push_back(chain_in);
                shifts++;
                run++;
                last_sh = cyc;
                if (!busy) busy_bad = 1'b1;
            end else if (run > 0) begin
                bursts.push_back(run);
                run = 0;
            end
            if (cfg_ready) begin
                rdy_cnt++;
                if (chain_shift_en) gap_bad = 1'b1;
            end
            if (widx == 1 && gapcnt < gap) begin
                cfg_valid = 1'b0;
                if (cfg_ready) gapcnt++;
            end else if (widx < 2) begin
                cfg_valid = 1'b1;
                cfg_data  = (widx == 0) ? W0 : W1;
                if (cfg_ready) widx++;
            end else begin
                cfg_valid = 1'b0;
            end
            tick();
        end
        cfg_valid = 1'b0;
        if (run > 0) bursts.push_back(run);

        chk({tag, " done cycle"}, done_cyc, 42 + gap + VCYC);
        chk({tag, " done follows last shift"}, done_cyc - last_sh, 1);
        chk({tag, " shift count"}, shifts, 40 + VCYC);
        chk({tag, " ready count"}, rdy_cnt, 2 + gap);
        chk({tag, " no shift while ready"}, gap_bad, 0);
        chk({tag, " busy while shifting"}, busy_bad, 0);
        chk({tag, " burst count"}, bursts.size(), 2);
        if (bursts.size() >= 2) begin
            chk({tag, " burst0"}, bursts[0], 32);
            chk({tag, " burst1"}, bursts[1], 8 + VCYC);
        end
        if (q.size() >= 40) begin
            for (int k = 0; k < 40; k++) if (q[k] !== stream[k]) nmis++;
            chk({tag, " bit mismatches"}, nmis, 0);
            chk({tag, " first bits"}, {q[0], q[1], q[2], q[3]}, 4'b1000);
            chk({tag, " last byte"}, {q[32], q[33], q[34], q[35], q[36], q[37], q[38], q[39]},
                8'b11000011);
        end
        chk({tag, " bits_loaded"}, bits_loaded, 40);
        chk({tag, " error"}, error, exp_err);
        chk({tag, " busy in done"}, busy, 0);
        chk({tag, " shift_en in done"}, chain_shift_en, 0);
        if (check_chain) chk({tag, " chain contents"}, chain, exp_chain);
        tick();
        tick();
        chk({tag, " done held"}, done, 1);
        chk({tag, " no extra ready"}, cfg_ready, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        q_start = 1'b0; q_valid = 1'b0; q_data = '0;
        tick(); tick(); tick();

        // Reset state
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ready", cfg_ready, 0);
        chk("rst shift_en", chain_shift_en, 0);
        chk("rst chain_in", chain_in, 0);
        chk("rst bits", bits_loaded, 0);
        chk("rst error", error, 0);
        rst_n = 1'b1;
        tick();
        chk("idle busy", busy, 0);

        // Basic and backpressured loads
        do_load("basic", 0, 1'b0, 1'b1);
        do_load("gap", 10, 1'b0, 1'b1);

        // Abort at the 20th shift cycle
        start = 1'b1; tick(); start = 1'b0;
        chk("ab ready", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_data = W0;
        tick();
        cfg_valid = 1'b0;
        repeat (19) tick();
        chk("ab shifting", chain_shift_en, 1);
        chk("ab bits before", bits_loaded, 19);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab busy", busy, 0);
        chk("ab done", done, 0);
        chk("ab shift_en", chain_shift_en, 0);
        chk("ab ready after", cfg_ready, 0);

        // Abort wins over a simultaneous handshake
        start = 1'b1; tick(); start = 1'b0;
        cfg_valid = 1'b1; cfg_data = W0; abort = 1'b1;
        tick();
        abort = 1'b0; cfg_valid = 1'b0;
        chk("ab-hs shift_en", chain_shift_en, 0);
        chk("ab-hs busy", busy, 0);
        do_load("post-abort", 0, 1'b0, 1'b1);

        // Synchronous reset in the middle of a shift burst
        start = 1'b1; tick(); start = 1'b0;
        cfg_valid = 1'b1; cfg_data = W0;
        tick();
        cfg_valid = 1'b0;
        repeat (9) tick();
        chk("rs shifting", chain_shift_en, 1);
        rst_n = 1'b0; start = 1'b1;
        tick();
        chk("rs busy", busy, 0);
        chk("rs done", done, 0);
        chk("rs ready", cfg_ready, 0);
        chk("rs shift_en", chain_shift_en, 0);
        chk("rs chain_in", chain_in, 0);
        chk("rs bits", bits_loaded, 0);
        chk("rs error", error, 0);
        tick();
        chk("rs start ignored busy", busy, 0);
        chk("rs start ignored ready", cfg_ready, 0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        chk("rs idle", busy, 0);
        do_load("post-reset", 0, 1'b0, 1'b1);

        // 64-bit chain: exact multiple of the word width
        begin
            int   widx = 0, shifts = 0, rdy = 0, done_cyc = -1;
            logic [63:0] stream64, exp64;
            stream64 = {X1, X0};
            for (int k = 0; k < 64; k++) exp64[63-k] = stream64[k];
            q_start = 1'b1; tick(); q_start = 1'b0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                if (q_done) begin
                    done_cyc = cyc;
                    break;
                end
                if (q_se) shifts++;
                if (q_ready) rdy++;
                if (widx < 2) begin
                    q_valid = 1'b1;
                    q_data  = (widx == 0) ? X0 : X1;
                    if (q_ready) widx++;
                end else begin
                    q_valid = 1'b0;
                end
                tick();
            end
            q_valid = 1'b0;
            chk("x64 shifts", shifts, 64 + VCYC64);
            chk("x64 ready count", rdy, 2);
            chk("x64 done cycle", done_cyc, 66 + VCYC64);
            chk("x64 bits", q_bits, 64);
            chk("x64 error", q_error, 0);
            chk("x64 chain", chain64, exp64);
            tick(); tick();
            chk("x64 no third ready", q_ready, 0);
            chk("x64 done held", q_done, 1);
        end

`ifdef CFG_CHAIN_READBACK_EN
        // One cell stuck at 0 corrupts the readback signature
        stuck_mask = 40'h1 << 17;
        do_load("stuck", 0, 1'b1, 1'b0);
        stuck_mask = '0;
        do_load("healed", 0, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
